dca_matrix_mreg2store: RTL

//  Drain stage of the DCA matrix register (mreg): after a compute, streams the mreg contents out
//  row by row as tensor-row beats to the store path, with an optional row-count limit. It always

---
 rtl/dca_matrix_mreg2store.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dca_matrix_mreg2store.sv
// Drain stage of the DCA matrix register: streams mreg rows out as tensor-row beats and always
// shifts the mreg exactly MATRIX_NUM_ROW times so it is realigned for the next load.
module dca_matrix_mreg2store #(
    parameter int MATRIX_NUM_ROW   = 4,
    parameter int MATRIX_NUM_COL   = 4,
    parameter int BW_TENSOR_SCALAR = 32,
    localparam int BW_TENSOR_ROW   = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
    localparam int BW_NUM_ROW      = $clog2(MATRIX_NUM_ROW + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     enable,
    output logic                     busy,
    input  logic                     storereg_wrequest,
    input  logic [BW_NUM_ROW-1:0]    storereg_num_row,
    output logic                     storereg_wready,
    output logic                     storereg_done,
    output logic                     mreg_move_renable,
    input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
    output logic                     store_tensor_row_rvalid,
    output logic                     store_tensor_row_rlast,
    output logic [BW_TENSOR_ROW-1:0] store_tensor_row_rdata,
    input  logic                     store_tensor_row_rready
);

    localparam int BW_CNT = $clog2(MATRIX_NUM_ROW);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [BW_NUM_ROW-1:0] NUM_ROW_MAX = BW_NUM_ROW'(MATRIX_NUM_ROW);
    localparam logic [BW_CNT-1:0]     CNT_LAST    = BW_CNT'(MATRIX_NUM_ROW - 1);

    logic [1:0]            state;
    logic [BW_CNT-1:0]     cnt;
    logic [BW_NUM_ROW-1:0] num_row_reg;
    logic [BW_NUM_ROW-1:0] num_row_clamped;
    logic                  row_last;
    logic                  hs;

    // A zero or oversized request means "emit every row".
    assign num_row_clamped = (storereg_num_row == '0 || storereg_num_row > NUM_ROW_MAX)
                             ? NUM_ROW_MAX : storereg_num_row;

    assign row_last = (BW_NUM_ROW'(cnt) == num_row_reg - BW_NUM_ROW'(1));
    assign hs       = store_tensor_row_rvalid & store_tensor_row_rready;

    // NOTE: state and counters use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            num_row_reg <= NUM_ROW_MAX;
        end else if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            num_row_reg <= NUM_ROW_MAX;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (storereg_wrequest) begin
                        num_row_reg <= num_row_clamped;
                        cnt         <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        cnt <= cnt + BW_CNT'(1);
                        if (row_last)
                            state <= (cnt == CNT_LAST) ? DONE : FLUSH;
                    end
                end
                FLUSH: begin
                    // Shift out the rows that were not emitted so the mreg ends up realigned.
                    cnt <= cnt + BW_CNT'(1);
                    if (cnt == CNT_LAST)
                        state <= DONE;
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so the combinational block cannot infer a latch.
    always_comb begin
        busy                    = 1'b0;
        storereg_wready         = 1'b0;
        storereg_done           = 1'b0;
        mreg_move_renable       = 1'b0;
        store_tensor_row_rvalid = 1'b0;
        store_tensor_row_rlast  = 1'b0;
        case (state)
            IDLE: storereg_wready = 1'b1;
            SEND: begin
                busy                    = 1'b1;
                store_tensor_row_rvalid = enable;
                store_tensor_row_rlast  = row_last;
                mreg_move_renable       = enable & store_tensor_row_rready;
            end
            FLUSH: begin
                busy              = 1'b1;
                mreg_move_renable = enable;
            end
            DONE: begin
                busy          = 1'b1;
                storereg_done = enable;
            end
            default: ;
        endcase
    end

    assign store_tensor_row_rdata = mreg_move_rdata_list1d;

endmodule
